// File: rtl/eye_lock_pkg.sv
// eye_lock_pkg: shared types and helpers for the eye lock controller.
//   lock_state_e : SEARCH / CONFIRM / LOCKED state enum
//   ST_*         : matching 2-bit state encodings used by the FSM
//   box_t        : one eye bounding box (up, down, left, right; 11 bits each)
//   abs_diff     : |a - b|, computed as a 12-bit signed difference
//   avg_round    : (a + b + 1) >> 1, computed at 12 bits
package eye_lock_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef struct packed {
    logic [10:0] up;
    logic [10:0] down;
    logic [10:0] left;
    logic [10:0] right;
  } box_t;

  function automatic logic [11:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    logic signed [11:0] d;
    d = signed'({1'b0, a}) - signed'({1'b0, b});
    return d[11] ? 12'(-d) : 12'(d);
  endfunction

  function automatic logic [10:0] avg_round(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b} + 12'd1;
    return s[11:1];
  endfunction

endpackage

// File: rtl/eye_lock_ctrl_cmp.sv
// eye_box_cmp: combinational check of one eye box.
//   cur        : box detected this frame
//   ref_box    : reference box from earlier frames
//   box_ok     : box well-formed (up < down, left < right) and inside the display
//   box_stable : box_ok and every edge within MAX_JITTER of the reference
import eye_lock_pkg::*;

module eye_box_cmp #(
  parameter int H_DISP     = 800,
  parameter int V_DISP     = 480,
  parameter int MAX_JITTER = 16
) (
  input  box_t cur,
  input  box_t ref_box,
  output logic box_ok,
  output logic box_stable
);

  localparam logic [11:0] H_LIM = 12'(H_DISP);
  localparam logic [11:0] V_LIM = 12'(V_DISP);
  localparam logic [11:0] JIT   = 12'(MAX_JITTER);

  always_comb begin
    // up < down < V_DISP implies up is in range too; same for left/right.
    box_ok = (cur.up < cur.down) && (cur.left < cur.right) &&
             ({1'b0, cur.down} < V_LIM) && ({1'b0, cur.right} < H_LIM);
    box_stable = box_ok &&
                 (abs_diff(cur.up,    ref_box.up)    <= JIT) &&
                 (abs_diff(cur.down,  ref_box.down)  <= JIT) &&
                 (abs_diff(cur.left,  ref_box.left)  <= JIT) &&
                 (abs_diff(cur.right, ref_box.right) <= JIT);
  end

endmodule

// File: rtl/eye_lock_ctrl.sv
// eye_lock_ctrl: per-frame eye lock controller for the LCD overlay.
//   lcd_clk, sys_rst          : pixel clock, async active-high reset
//   frame_done                : end-of-frame strobe; detector inputs valid this cycle
//   det_valid, eye1_*, eye2_* : detector result for this frame
//   eye_lock                  : 11'h7FF while LOCKED, else 0
//   eye1_*_trk, eye2_*_trk    : margin-expanded tracking windows (0 unless LOCKED)
//   lock_state                : 0 SEARCH, 1 CONFIRM, 2 LOCKED
//   lock_evt                  : one-cycle pulse on entry to LOCKED
// Optional macro EYE_LOCK_SMOOTH_EN: stable LOCKED frames average the new box
// into the reference instead of replacing it.
//
// state   | meaning
// SEARCH  | no candidate; waiting for a well-formed pair of boxes
// CONFIRM | candidate seen; counting consecutive stable frames
// LOCKED  | lock held; counting consecutive bad frames
import eye_lock_pkg::*;

module eye_lock_ctrl #(
  parameter int H_DISP         = 800,
  parameter int V_DISP         = 480,
  parameter int CONFIRM_FRAMES = 4,
  parameter int LOST_FRAMES    = 8,
  parameter int MAX_JITTER     = 16,
  parameter int TRK_MARGIN     = 20
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic        frame_done,
  input  logic        det_valid,
  input  logic [10:0] eye1_up,
  input  logic [10:0] eye1_down,
  input  logic [10:0] eye1_left,
  input  logic [10:0] eye1_right,
  input  logic [10:0] eye2_up,
  input  logic [10:0] eye2_down,
  input  logic [10:0] eye2_left,
  input  logic [10:0] eye2_right,
  output logic [10:0] eye_lock,
  output logic [10:0] eye1_up_trk,
  output logic [10:0] eye1_down_trk,
  output logic [10:0] eye1_left_trk,
  output logic [10:0] eye1_right_trk,
  output logic [10:0] eye2_up_trk,
  output logic [10:0] eye2_down_trk,
  output logic [10:0] eye2_left_trk,
  output logic [10:0] eye2_right_trk,
  output logic [1:0]  lock_state,
  output logic        lock_evt
);

  localparam logic [3:0]  CONF_N = 4'(CONFIRM_FRAMES);
  localparam logic [3:0]  LOST_N = 4'(LOST_FRAMES);
  localparam logic [11:0] MARG   = 12'(TRK_MARGIN);
  localparam logic [11:0] X_MAX  = 12'(H_DISP - 1);
  localparam logic [11:0] Y_MAX  = 12'(V_DISP - 1);

  box_t       new1, new2;
  box_t       ref1, ref2, ref1_n, ref2_n;
  box_t       trk1, trk2;
  logic [1:0] state, state_n;
  logic [3:0] cnt, cnt_n, miss, miss_n;
  logic       evt_n;
  logic       ok1, ok2, st1, st2, geo_ok, stable;

  assign new1 = '{up: eye1_up, down: eye1_down, left: eye1_left, right: eye1_right};
  assign new2 = '{up: eye2_up, down: eye2_down, left: eye2_left, right: eye2_right};

  eye_box_cmp #(.H_DISP(H_DISP), .V_DISP(V_DISP), .MAX_JITTER(MAX_JITTER)) u_cmp1 (
    .cur(new1), .ref_box(ref1), .box_ok(ok1), .box_stable(st1)
  );

  eye_box_cmp #(.H_DISP(H_DISP), .V_DISP(V_DISP), .MAX_JITTER(MAX_JITTER)) u_cmp2 (
    .cur(new2), .ref_box(ref2), .box_ok(ok2), .box_stable(st2)
  );

  assign geo_ok = det_valid && ok1 && ok2 && (eye1_right < eye2_left);
  assign stable = geo_ok && st1 && st2;

  function automatic logic [10:0] lo_edge(input logic [10:0] v);
    logic [11:0] w;
    w = {1'b0, v};
    return (w >= MARG) ? 11'(w - MARG) : 11'd0;
  endfunction

  function automatic logic [10:0] hi_edge(input logic [10:0] v, input logic [11:0] lim);
    logic [11:0] w;
    w = {1'b0, v} + MARG;
    return (w > lim) ? 11'(lim) : 11'(w);
  endfunction

  function automatic box_t expand(input box_t b);
    box_t e;
    e.up    = lo_edge(b.up);
    e.left  = lo_edge(b.left);
    e.down  = hi_edge(b.down, Y_MAX);
    e.right = hi_edge(b.right, X_MAX);
    return e;
  endfunction

`ifdef EYE_LOCK_SMOOTH_EN
  function automatic box_t blend(input box_t r, input box_t n);
    box_t m;
    m.up    = avg_round(r.up,    n.up);
    m.down  = avg_round(r.down,  n.down);
    m.left  = avg_round(r.left,  n.left);
    m.right = avg_round(r.right, n.right);
    return m;
  endfunction
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    miss_n  = miss;
    ref1_n  = ref1;
    ref2_n  = ref2;
    evt_n   = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (geo_ok) begin
          ref1_n = new1;
          ref2_n = new2;
          cnt_n  = 4'd1;
          if (CONF_N == 4'd1) begin
            state_n = ST_LOCKED;
            miss_n  = 4'd0;
            evt_n   = 1'b1;
          end else begin
            state_n = ST_CONFIRM;
          end
        end
      end
      ST_CONFIRM: begin
        if (stable) begin
          ref1_n = new1;
          ref2_n = new2;
          cnt_n  = cnt + 4'd1;
          if (cnt_n == CONF_N) begin
            state_n = ST_LOCKED;
            miss_n  = 4'd0;
            evt_n   = 1'b1;
          end
        end else begin
          state_n = ST_SEARCH;
          cnt_n   = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (stable) begin
`ifdef EYE_LOCK_SMOOTH_EN
          ref1_n = blend(ref1, new1);
          ref2_n = blend(ref2, new2);
`else
          ref1_n = new1;
          ref2_n = new2;
`endif
          miss_n = 4'd0;
        end else begin
          miss_n = miss + 4'd1;
          if (miss_n == LOST_N) begin
            state_n = ST_SEARCH;
            cnt_n   = 4'd0;
            miss_n  = 4'd0;
          end
        end
      end
      default: begin
        state_n = ST_SEARCH;
        cnt_n   = 4'd0;
        miss_n  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_SEARCH;
      cnt      <= 4'd0;
      miss     <= 4'd0;
      ref1     <= '0;
      ref2     <= '0;
      trk1     <= '0;
      trk2     <= '0;
      eye_lock <= 11'd0;
      lock_evt <= 1'b0;
    end else begin
      lock_evt <= frame_done && evt_n;
      if (frame_done) begin
        state <= state_n;
        cnt   <= cnt_n;
        miss  <= miss_n;
        ref1  <= ref1_n;
        ref2  <= ref2_n;
        // Windows are registered from next-state values so they track the
        // state change in the same cycle.
        if (state_n == ST_LOCKED) begin
          trk1     <= expand(ref1_n);
          trk2     <= expand(ref2_n);
          eye_lock <= 11'h7FF;
        end else begin
          trk1     <= '0;
          trk2     <= '0;
          eye_lock <= 11'd0;
        end
      end
    end
  end

  assign lock_state     = state;
  assign eye1_up_trk    = trk1.up;
  assign eye1_down_trk  = trk1.down;
  assign eye1_left_trk  = trk1.left;
  assign eye1_right_trk = trk1.right;
  assign eye2_up_trk    = trk2.up;
  assign eye2_down_trk  = trk2.down;
  assign eye2_left_trk  = trk2.left;
  assign eye2_right_trk = trk2.right;

endmodule

// File: tb/tb_eye_lock_ctrl.sv
`timescale 1ns/1ps
module tb_eye_lock_ctrl;

  logic        lcd_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        frame_done = 1'b0;
  logic        det_valid = 1'b0;
  logic [10:0] eye1_up = '0, eye1_down = '0, eye1_left = '0, eye1_right = '0;
  logic [10:0] eye2_up = '0, eye2_down = '0, eye2_left = '0, eye2_right = '0;
  logic [10:0] eye_lock;
  logic [10:0] eye1_up_trk, eye1_down_trk, eye1_left_trk, eye1_right_trk;
  logic [10:0] eye2_up_trk, eye2_down_trk, eye2_left_trk, eye2_right_trk;
  logic [1:0]  lock_state;
  logic        lock_evt;

  int n_chk  = 0;
  int n_pass = 0;

  eye_lock_ctrl dut (
    .lcd_clk(lcd_clk), .sys_rst(sys_rst), .frame_done(frame_done), .det_valid(det_valid),
    .eye1_up(eye1_up), .eye1_down(eye1_down), .eye1_left(eye1_left), .eye1_right(eye1_right),
    .eye2_up(eye2_up), .eye2_down(eye2_down), .eye2_left(eye2_left), .eye2_right(eye2_right),
    .eye_lock(eye_lock),
    .eye1_up_trk(eye1_up_trk), .eye1_down_trk(eye1_down_trk),
    .eye1_left_trk(eye1_left_trk), .eye1_right_trk(eye1_right_trk),
    .eye2_up_trk(eye2_up_trk), .eye2_down_trk(eye2_down_trk),
    .eye2_left_trk(eye2_left_trk), .eye2_right_trk(eye2_right_trk),
    .lock_state(lock_state), .lock_evt(lock_evt)
  );

  always #5 lcd_clk = ~lcd_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One frame: drive inputs with frame_done high across one rising edge.
  // Successive calls produce back-to-back frame_done pulses.
  task automatic frame(input logic dv,
                       input logic [10:0] u1, input logic [10:0] d1,
                       input logic [10:0] l1, input logic [10:0] r1,
                       input logic [10:0] u2, input logic [10:0] d2,
                       input logic [10:0] l2, input logic [10:0] r2);
    det_valid = dv;
    eye1_up = u1; eye1_down = d1; eye1_left = l1; eye1_right = r1;
    eye2_up = u2; eye2_down = d2; eye2_left = l2; eye2_right = r2;
    frame_done = 1'b1;
    @(negedge lcd_clk);
    frame_done = 1'b0;
  endtask

  task automatic base_frame();
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd400, 11'd460);
  endtask

  task automatic do_reset();
    @(negedge lcd_clk);
    sys_rst = 1'b1;
    @(negedge lcd_clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge lcd_clk);
    sys_rst = 1'b0;

    chk("rst_state", lock_state, 0);
    chk("rst_lock", eye_lock, 0);
    chk("rst_evt", lock_evt, 0);
    chk("rst_trk", eye1_up_trk | eye2_right_trk, 0);

    // Clean lock
    base_frame();
    chk("f1_state", lock_state, 1);
    chk("f1_evt", lock_evt, 0);
    chk("f1_trk", eye1_up_trk, 0);
    base_frame();
    base_frame();
    chk("f3_state", lock_state, 1);
    chk("f3_lock", eye_lock, 0);
    base_frame();
    chk("lock_state", lock_state, 2);
    chk("lock_evt", lock_evt, 1);
    chk("lock_mask", eye_lock, 11'h7FF);
    chk("e1_up_trk", eye1_up_trk, 80);
    chk("e1_down_trk", eye1_down_trk, 160);
    chk("e1_left_trk", eye1_left_trk, 180);
    chk("e1_right_trk", eye1_right_trk, 280);
    chk("e2_left_trk", eye2_left_trk, 380);
    chk("e2_right_trk", eye2_right_trk, 480);
    @(negedge lcd_clk);
    chk("evt_one_cycle", lock_evt, 0);

    // Idle cycles with garbage inputs: nothing changes without frame_done
    det_valid = 1'b0; eye1_up = 11'd7; eye2_left = 11'd9;
    repeat (5) @(negedge lcd_clk);
    chk("idle_state", lock_state, 2);
    chk("idle_trk", eye1_up_trk, 80);

    // Loss: 7 bad frames hold, 8th drops
    for (int i = 0; i < 7; i++)
      frame(1'b0, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd400, 11'd460);
    chk("loss7_state", lock_state, 2);
    chk("loss7_trk", eye1_left_trk, 180);
    chk("loss7_mask", eye_lock, 11'h7FF);
    frame(1'b0, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd400, 11'd460);
    chk("loss8_state", lock_state, 0);
    chk("loss8_mask", eye_lock, 0);
    chk("loss8_trk", eye1_up_trk | eye1_left_trk | eye2_right_trk, 0);
    chk("loss8_evt", lock_evt, 0);

    // Jitter break: 17 px move in CONFIRM drops to SEARCH
    base_frame();
    chk("jit_confirm", lock_state, 1);
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd417, 11'd460);
    chk("jit17_state", lock_state, 0);
    // 16 px move still confirms
    base_frame();
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd416, 11'd460);
    chk("jit16_state", lock_state, 1);
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd416, 11'd460);
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd416, 11'd460);
    chk("jit16_lock", lock_state, 2);
    chk("jit16_evt", lock_evt, 1);
    chk("jit16_e2_left", eye2_left_trk, 396);

    // Async reset mid-lock clears outputs immediately
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_state", lock_state, 0);
    chk("arst_mask", eye_lock, 0);
    chk("arst_trk", eye2_left_trk | eye1_up_trk, 0);
    @(negedge lcd_clk);
    sys_rst = 1'b0;

    // Reset in the same cycle as frame_done discards the frame
    sys_rst = 1'b1;
    base_frame();
    sys_rst = 1'b0;
    chk("rst_wins", lock_state, 0);

    // Clamp at display edges
    for (int i = 0; i < 4; i++)
      frame(1'b1, 11'd5, 11'd40, 11'd200, 11'd260, 11'd100, 11'd140, 11'd740, 11'd795);
    chk("clamp_state", lock_state, 2);
    chk("clamp_e1_up", eye1_up_trk, 0);
    chk("clamp_e1_down", eye1_down_trk, 60);
    chk("clamp_e2_right", eye2_right_trk, 799);
    chk("clamp_e2_left", eye2_left_trk, 720);

    // Stable LOCKED update: ref down 40, new 50
    frame(1'b1, 11'd5, 11'd50, 11'd200, 11'd260, 11'd100, 11'd140, 11'd740, 11'd795);
`ifdef EYE_LOCK_SMOOTH_EN
    chk("upd_e1_down", eye1_down_trk, 65);
`else
    chk("upd_e1_down", eye1_down_trk, 70);
`endif
    chk("upd_state", lock_state, 2);

    // Geometry rejects
    do_reset();
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd400, 11'd100, 11'd140, 11'd400, 11'd460);
    chk("geo_overlap", lock_state, 0);
    frame(1'b1, 11'd140, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd400, 11'd460);
    chk("geo_updown", lock_state, 0);
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd400, 11'd800);
    chk("geo_xrange", lock_state, 0);
    frame(1'b1, 11'd100, 11'd480, 11'd200, 11'd260, 11'd100, 11'd140, 11'd400, 11'd460);
    chk("geo_yrange", lock_state, 0);
    frame(1'b0, 11'd100, 11'd140, 11'd200, 11'd260, 11'd100, 11'd140, 11'd400, 11'd460);
    chk("geo_novalid", lock_state, 0);
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd399, 11'd100, 11'd140, 11'd400, 11'd460);
    chk("geo_adjacent_ok", lock_state, 1);
    // Geometry failure in CONFIRM also drops back
    frame(1'b1, 11'd100, 11'd140, 11'd200, 11'd400, 11'd100, 11'd140, 11'd400, 11'd460);
    chk("geo_confirm_drop", lock_state, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
